// File: rtl/cond_logic_stage.sv
`default_nettype none
// ============================================================================
//  Module   : cond_logic_stage
//  Purpose  : Execute-stage conditional-execution unit. Holds the NZCV flags
//             register, evaluates the condition field against it, gates the
//             write/branch controls and drives the EX/MEM control register.
//             Also keeps saturating debug counters of taken PC writes and
//             condition-failed instructions.
//  Revision : 1.0  initial release
// ============================================================================
module cond_logic_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  output logic [3:0]       Flags,
  output logic             CondEx,
  output logic             PCSrcE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             valid_m,
  output logic [CNT_W-1:0] br_taken_cnt,
  output logic [CNT_W-1:0] cond_fail_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       flags_q, flags_d;
  logic             regwrite_q, memwrite_q, valid_q;
  logic [CNT_W-1:0] br_cnt_q, fail_cnt_q;

  logic flag_n, flag_z, flag_c, flag_v, ge;
  logic cond_ex, adv, fire;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;
  assign ge = (flag_n == flag_v);

  // Condition decode from the registered flags; 1111 yields a defined 0.
  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~(flag_c & ~flag_z);
      4'b1010: cond_ex = ge;
      4'b1011: cond_ex = ~ge;
      4'b1100: cond_ex = ~flag_z & ge;
      4'b1101: cond_ex = ~(~flag_z & ge);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // An instruction only takes effect when it advances out of EX.
  assign adv  = ex_valid & ~stall & ~flush;
  assign fire = adv & cond_ex;

  // Flag pairs update independently; each holds unless its FlagW bit fires.
  always_comb begin
    flags_d = flags_q;
    if (fire && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
    if (fire && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
  end

  // Flags, EX/MEM control register and saturating debug counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q    <= 4'b0000;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      valid_q    <= 1'b0;
      br_cnt_q   <= '0;
      fail_cnt_q <= '0;
    end else begin
      flags_q    <= flags_d;
      // Stall or flush hands MEM a bubble rather than holding it.
      valid_q    <= adv;
      regwrite_q <= fire & RegW & ~NoWrite;
      memwrite_q <= fire & MemW;
      if (fire && PCS && (br_cnt_q != C_CNT_MAX))
        br_cnt_q <= br_cnt_q + 1'b1;
      if (adv && !cond_ex && (fail_cnt_q != C_CNT_MAX))
        fail_cnt_q <= fail_cnt_q + 1'b1;
    end
  end

  assign Flags         = flags_q;
  assign CondEx        = cond_ex;
  assign PCSrcE        = fire & PCS;
  assign RegWriteM     = regwrite_q;
  assign MemWriteM     = memwrite_q;
  assign valid_m       = valid_q;
  assign br_taken_cnt  = br_cnt_q;
  assign cond_fail_cnt = fail_cnt_q;

endmodule
`default_nettype wire

// File: doc/cond_logic_stage.md
Name: cond_logic_stage

Overview:
- Execute-stage conditional-execution unit for the pipelined ARM core.
- Holds the architectural NZCV flags register and evaluates the instruction's 4-bit condition field against it.
- Gates register-write, memory-write and branch control by the condition result, and drives the EX/MEM control register.
- Keeps saturating counters of taken branches and condition-failed instructions for debug.

Parameters:
- CNT_W, 16, width of each saturating performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ex_valid  input  1  EX stage holds a real instruction.
- stall  input  1  EX stage held this cycle; instruction does not advance.
- flush  input  1  EX instruction squashed this cycle.
- Cond  input  4  instruction condition field [31:28].
- ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  input  2  [1] updates N,Z; [0] updates C,V.
- PCS  input  1  instruction writes PC (branch or PC-destination).
- RegW  input  1  instruction writes the register file.
- MemW  input  1  instruction writes memory.
- NoWrite  input  1  compare-class instruction; suppresses the register write.
- Flags  output  4  current flags register {N,Z,C,V}.
- CondEx  output  1  combinational condition result from the Flags register.
- PCSrcE  output  1  combinational branch redirect to fetch.
- RegWriteM  output  1  registered register-write enable to MEM.
- MemWriteM  output  1  registered memory-write enable to MEM.
- valid_m  output  1  registered MEM-stage valid.
- br_taken_cnt  output  CNT_W  saturating count of taken PC writes.
- cond_fail_cnt  output  CNT_W  saturating count of advanced instructions with CondEx=0.

Behaviour:
- Reset: a synchronous reset clears Flags, RegWriteM, MemWriteM, valid_m and both counters to 0 on the next edge. Reset dominates every other input, including mid-stall and mid-flush.
- Condition evaluation (combinational, from the registered Flags; ge = (N==V)):
  - 0000 EQ: Z. 0001 NE: ~Z.
  - 0010 CS: C. 0011 CC: ~C.
  - 0100 MI: N. 0101 PL: ~N.
  - 0110 VS: V. 0111 VC: ~V.
  - 1000 HI: C&~Z. 1001 LS: ~(C&~Z).
  - 1010 GE: ge. 1011 LT: ~ge.
  - 1100 GT: ~Z&ge. 1101 LE: ~(~Z&ge).
  - 1110 AL: 1.
  - 1111: 0, a defined value; never X.
- adv = ex_valid & ~stall & ~flush.
- fire = adv & CondEx.
- Flags update on clock edge:
  - If fire & FlagW[1]: N,Z <= ALUFlags[3:2].
  - If fire & FlagW[0]: C,V <= ALUFlags[1:0].
  - Otherwise each pair holds its value.
  - A flag-setting instruction in cycle t is visible to the EX instruction in cycle t+1; no bypass path is required.
- PCSrcE = fire & PCS. It is combinational and is 0 whenever stall, flush or ~ex_valid.
- EX/MEM control register, updated every edge that reset is not asserted:
  - valid_m <= adv.
  - RegWriteM <= fire & RegW & ~NoWrite.
  - MemWriteM <= fire & MemW.
  - While stall or flush is asserted, MEM receives a bubble (all three 0). Stall does not hold MEM.
  - Flush and stall together behave identically to flush alone.
- Counters:
  - br_taken_cnt += 1 when fire & PCS.
  - cond_fail_cnt += 1 when adv & ~CondEx.
  - Both saturate at 2^CNT_W-1 and never wrap. They are reset only by reset.
- Latency: CondEx and PCSrcE in the same cycle; MEM controls one cycle later; flag writes effective one cycle later.
- Do-not-care inputs: when ex_valid=0, Cond, FlagW, PCS, RegW, MemW and NoWrite are don't-care. No state changes except that valid_m and the MEM controls load 0.

Test Plan:
- Reset then idle: assert reset for 2 cycles with random inputs -> Flags=0000, RegWriteM=MemWriteM=valid_m=0, both counters 0; next cycle Cond=1110, RegW=1, ex_valid=1 -> RegWriteM=1 one cycle later.
- Partial flag write: Flags=0000; issue AL, FlagW=10, ALUFlags=1111 -> Flags=1100; next issue AL, FlagW=01, ALUFlags=0000 -> Flags=1100 (C,V already 0); then AL, FlagW=01, ALUFlags=0011 -> Flags=1111.
- Condition sweep: for every Flags value (16) x every Cond (16) with PCS=1 -> PCSrcE matches the table; Cond=1111 always gives PCSrcE=0; br_taken_cnt equals the number of true entries.
- Failed condition suppression: Flags Z=0, Cond=0000 (EQ), RegW=MemW=1, FlagW=11, ALUFlags=0100 -> CondEx=0; RegWriteM=MemWriteM=0 and valid_m=1 next cycle; Flags unchanged; cond_fail_cnt +1.
- Stall and flush: AL with PCS=1, FlagW=11, ALUFlags=1010 and stall=1 -> PCSrcE=0, Flags unchanged, valid_m=0 next cycle; the same instruction with flush=1 gives the same result; with both deasserted -> PCSrcE=1, Flags=1010.
- Saturation and compare: CNT_W=4, 20 taken branches -> br_taken_cnt stops at 15; CMP-type (RegW=1, NoWrite=1, AL) -> RegWriteM=0.
